// File: rtl/miracle_host.sv
// rtl/miracle_host.sv - host side of the Miracle piano joypad-port serial link
//
// Bit-bangs bytes to / polls bytes from the piano over the joypad port.
// All port line changes and all state counters are paced by clk_cpu ticks.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   clk_cpu             one-clk enable pulse, one pulse = one cpu tick
//   tx_valid/tx_data    byte offered for transmission (taken when tx_ready=1)
//   tx_ready            idle with no byte held
//   poll_en             allows automatic read polling
//   rx_valid/rx_data    one-clk pulse with a received byte
//   busy                a transaction is in progress
//   strobe              port strobe line (also carries write data)
//   joypad_clock        port clock line
//   joypad_i            port serial data line (carries complemented data)
module miracle_host #(
  parameter int READ_STB  = 12,
  parameter int WRITE_STB = 70,
  parameter int GAP       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_cpu,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       poll_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       strobe,
  output logic       joypad_clock,
  input  logic       joypad_i
);

  typedef enum logic [2:0] {
    IDLE, RSTB, RGAP, RBIT, WSTB, WGAP, WBIT, WEND
  } state_t;

  localparam logic [7:0] READ_LAST  = 8'(READ_STB - 1);
  localparam logic [7:0] WRITE_LAST = 8'(WRITE_STB - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);
  localparam logic [7:0] GAP_C      = 8'(GAP);

  // Read bit phase 3 is the single tick that samples the valid flag.
  localparam logic [1:0] PH_FLAG = 2'd3;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [1:0] phase, phase_n;
  logic       held, held_n;
  logic [7:0] tx_byte, byte_n;
  logic [7:0] rx_shift, shift_n;
  logic       stb_n, jclk_n, rxv_n;
  logic [7:0] rxd_n;
  logic       take;

  assign tx_ready = (state == IDLE) && !held;
  assign busy     = (state != IDLE);
  assign take     = tx_ready && tx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      bit_idx      <= 3'd0;
      phase        <= 2'd0;
      held         <= 1'b0;
      tx_byte      <= 8'd0;
      rx_shift     <= 8'd0;
      strobe       <= 1'b0;
      joypad_clock <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= 8'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_n;
      phase        <= phase_n;
      held         <= held_n;
      tx_byte      <= byte_n;
      rx_shift     <= shift_n;
      strobe       <= stb_n;
      joypad_clock <= jclk_n;
      rx_valid     <= rxv_n;
      rx_data      <= rxd_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    phase_n = phase;
    held_n  = held;
    byte_n  = tx_byte;
    shift_n = rx_shift;
    stb_n   = strobe;
    jclk_n  = joypad_clock;
    rxv_n   = 1'b0;
    rxd_n   = rx_data;

    if (take) begin
      held_n = 1'b1;
      byte_n = tx_data;
    end

    if (clk_cpu) begin
      case (state)
        IDLE: begin
          // cnt counts quiet ticks since reset; returns from a transaction
          // preload it so polling continues without extra delay.
          if (cnt < GAP_C) begin
            cnt_n = cnt + 8'd1;
          end else if (held_n) begin
            // A byte taken on this very edge still wins over polling.
            state_n = WSTB;
            stb_n   = 1'b1;
            cnt_n   = 8'd0;
          end else if (poll_en) begin
            state_n = RSTB;
            stb_n   = 1'b1;
            cnt_n   = 8'd0;
          end
        end

        RSTB: begin
          if (cnt == READ_LAST) begin
            state_n = RGAP;
            stb_n   = 1'b0;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end

        RGAP: begin
          if (cnt == GAP_LAST) begin
            state_n = RBIT;
            phase_n = PH_FLAG;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end

        RBIT: begin
          case (phase)
            PH_FLAG: begin
              if (joypad_i) begin
                phase_n = 2'd0;
                bit_n   = 3'd7;
                jclk_n  = 1'b1;
              end else begin
                state_n = IDLE;
                cnt_n   = GAP_C;
              end
            end
            2'd0: begin
              jclk_n  = 1'b0;
              phase_n = 2'd1;
            end
            2'd1: phase_n = 2'd2;
            default: begin
              shift_n = {rx_shift[6:0], joypad_i};
              if (bit_idx == 3'd0) begin
                // Wire data is inverted; undo it on delivery.
                state_n = IDLE;
                cnt_n   = GAP_C;
                rxv_n   = 1'b1;
                rxd_n   = ~{rx_shift[6:0], joypad_i};
              end else begin
                bit_n   = bit_idx - 3'd1;
                phase_n = 2'd0;
                jclk_n  = 1'b1;
              end
            end
          endcase
        end

        WSTB: begin
          if (cnt == WRITE_LAST) begin
            state_n = WGAP;
            stb_n   = 1'b0;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end

        WGAP: begin
          if (cnt == GAP_LAST) begin
            state_n = WBIT;
            phase_n = 2'd0;
            bit_n   = 3'd7;
            stb_n   = tx_byte[7];
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end

        WBIT: begin
          case (phase)
            2'd0: begin
              jclk_n  = 1'b1;
              phase_n = 2'd1;
            end
            2'd1: begin
              jclk_n  = 1'b0;
              phase_n = 2'd2;
            end
            default: begin
              if (bit_idx == 3'd0) begin
                state_n = WEND;
                stb_n   = 1'b0;
                cnt_n   = 8'd0;
              end else begin
                bit_n   = bit_idx - 3'd1;
                phase_n = 2'd0;
                stb_n   = tx_byte[bit_idx - 3'd1];
              end
            end
          endcase
        end

        WEND: begin
          if (cnt == GAP_LAST) begin
            state_n = IDLE;
            held_n  = 1'b0;
            cnt_n   = GAP_C;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miracle_host.sv
// tb/tb_miracle_host.sv - directed self-checking bench for miracle_host with a piano-side model
module tb_miracle_host;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_cpu = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_ready;
  logic       poll_en = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       strobe;
  logic       joypad_clock;
  logic       joypad_i;

  int checks = 0;
  int failures = 0;

  miracle_host dut (
    .clk(clk), .reset(reset), .clk_cpu(clk_cpu),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .poll_en(poll_en), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .strobe(strobe), .joypad_clock(joypad_clock),
    .joypad_i(joypad_i)
  );

  always #5 clk = ~clk;

  // One cpu tick every 12 clk.
  int div = 0;
  always @(posedge clk) begin
    div     <= (div == 11) ? 0 : div + 1;
    clk_cpu <= (div == 10);
  end

  // Piano-side device model
  logic       wr_active = 1'b0;
  logic       rd_flag = 1'b0;
  logic [7:0] rd_byte = 8'd0;
  logic [7:0] wr_shift = 8'd0;
  int         wr_bits = 0;
  int         rise_cnt = 0;
  int         hi_clk = 0;
  logic       m_stb = 1'b0;
  logic       m_jc = 1'b0;
  logic [7:0] dev_q[$];
  logic [7:0] cap_q[$];

  always @(posedge clk) begin
    m_stb <= strobe;
    m_jc  <= joypad_clock;
    if (reset) begin
      wr_active <= 1'b0;
      rd_flag   <= 1'b0;
      rise_cnt  <= 0;
      wr_bits   <= 0;
      hi_clk    <= 0;
    end else begin
      if (strobe === 1'b1) hi_clk <= hi_clk + 1;
      if (m_stb === 1'b1 && strobe === 1'b0) begin
        hi_clk <= 0;
        if (!wr_active) begin
          if (hi_clk > 500) begin
            wr_active <= 1'b1;
            wr_bits   <= 0;
          end else if (hi_clk > 100) begin
            rise_cnt <= 0;
            if (dev_q.size() > 0) begin
              rd_flag <= 1'b1;
              rd_byte <= dev_q.pop_front();
            end else begin
              rd_flag <= 1'b0;
            end
          end
        end
      end
      if (m_jc === 1'b0 && joypad_clock === 1'b1) begin
        if (wr_active) begin
          wr_shift <= {wr_shift[6:0], strobe};
          if (wr_bits == 7) begin
            cap_q.push_back({wr_shift[6:0], strobe});
            wr_active <= 1'b0;
          end
          wr_bits <= wr_bits + 1;
        end else begin
          rise_cnt <= rise_cnt + 1;
        end
      end
    end
  end

  always_comb begin
    joypad_i = 1'b0;
    if (rise_cnt == 0) joypad_i = rd_flag;
    else if (rise_cnt <= 8) joypad_i = ~rd_byte[8 - rise_cnt];
  end

  // Line monitors
  int   change_viol = 0, gap_viol = 0, bad_width = 0, clk_pulses = 0;
  int   busy_rises = 0, busy_len = 0, rx_cnt = 0;
  int   hi_run = 0, low_run = 0, ck_run = 0, busy_run = 0;
  logic p_stb = 1'b0, p_jc = 1'b0, p_cpu = 1'b0, p_reset = 1'b1, p_busy = 1'b0;
  int   stb_lens[$];
  int   low_lens[$];
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (!p_reset && !p_cpu && (strobe !== p_stb || joypad_clock !== p_jc)) change_viol++;
    if (p_stb === 1'b1 && strobe === 1'b0) begin
      stb_lens.push_back(hi_run);
      hi_run = 0;
    end
    if (p_stb === 1'b0 && strobe === 1'b1) begin
      low_lens.push_back(low_run);
      if (low_run < 2) gap_viol++;
      low_run = 0;
    end
    if (p_jc === 1'b0 && joypad_clock === 1'b1) clk_pulses++;
    if (p_jc === 1'b1 && joypad_clock === 1'b0) begin
      if (ck_run != 1) bad_width++;
      ck_run = 0;
    end
    if (p_busy === 1'b0 && busy === 1'b1) busy_rises++;
    if (p_busy === 1'b1 && busy === 1'b0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (reset) begin
      hi_run = 0; low_run = 0; ck_run = 0; busy_run = 0;
    end else if (clk_cpu) begin
      if (strobe === 1'b1) hi_run++;
      if (strobe === 1'b0) low_run++;
      if (joypad_clock === 1'b1) ck_run++;
      if (busy === 1'b1) busy_run++;
    end
    p_stb = strobe; p_jc = joypad_clock; p_cpu = clk_cpu;
    p_reset = reset; p_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    stb_lens.delete(); low_lens.delete(); rx_q.delete(); cap_q.delete();
    clk_pulses = 0; bad_width = 0; rx_cnt = 0; busy_rises = 0; busy_len = 0;
  endtask

  task automatic wait_busy(input logic val, input int max_clk, input string tag);
    int n = 0;
    while (busy !== val && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, {31'd0, val});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_strobe", strobe, 0);
    check("rst_jclk", joypad_clock, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;

    // Write 0xA5
    clear_mon();
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("wr_byte_held", tx_ready, 0);
    wait_busy(1'b1, 100, "wr_a5_start");
    wait_busy(1'b0, 1400, "wr_a5_done");
    repeat (2) @(negedge clk);
    check("wr_a5_stb_len", (stb_lens.size() > 0) ? stb_lens[0] : -1, 70);
    check("wr_a5_gap_low", (low_lens.size() > 1) ? low_lens[1] : -1, 2);
    check("wr_a5_captured", (cap_q.size() > 0) ? {24'd0, cap_q[0]} : 32'hffff_ffff, 8'hA5);
    check("wr_a5_pulses", clk_pulses, 8);
    check("wr_a5_pulse_width", bad_width, 0);
    check("wr_a5_ticks", busy_len, 98);
    check("wr_a5_ready_back", tx_ready, 1);

    // Read, valid byte 0x3C; poll_en dropped mid-read
    clear_mon();
    dev_q.push_back(8'h3C);
    poll_en = 1'b1;
    wait_busy(1'b1, 100, "rd_3c_start");
    poll_en = 1'b0;
    wait_busy(1'b0, 600, "rd_3c_done");
    repeat (2) @(negedge clk);
    check("rd_3c_rx_cnt", rx_cnt, 1);
    check("rd_3c_rx_data", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hffff_ffff, 8'h3C);
    check("rd_3c_pulses", clk_pulses, 8);
    check("rd_3c_stb_len", (stb_lens.size() > 0) ? stb_lens[0] : -1, 12);
    check("rd_3c_ticks", busy_len, 39);

    // Read, empty
    clear_mon();
    poll_en = 1'b1;
    wait_busy(1'b1, 100, "rd_empty_start");
    poll_en = 1'b0;
    wait_busy(1'b0, 600, "rd_empty_done");
    repeat (2) @(negedge clk);
    check("rd_empty_ticks", busy_len, 15);
    check("rd_empty_pulses", clk_pulses, 0);
    check("rd_empty_rx_cnt", rx_cnt, 0);

    // Write has priority over poll
    clear_mon();
    dev_q.push_back(8'h77);
    tx_data = 8'h5A; tx_valid = 1'b1; poll_en = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_busy(1'b1, 100, "prio_wr_start");
    wait_busy(1'b0, 1400, "prio_wr_done");
    check("prio_first_is_write", (stb_lens.size() > 0) ? stb_lens[0] : -1, 70);
    check("prio_captured", (cap_q.size() > 0) ? {24'd0, cap_q[0]} : 32'hffff_ffff, 8'h5A);
    check("prio_no_rx_yet", rx_cnt, 0);
    wait_busy(1'b1, 100, "prio_rd_start");
    poll_en = 1'b0;
    wait_busy(1'b0, 600, "prio_rd_done");
    repeat (2) @(negedge clk);
    check("prio_rx_data", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hffff_ffff, 8'h77);

    // Reset during the 4th data bit of a write of 0x96
    clear_mon();
    tx_data = 8'h96; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    begin
      int n = 0;
      while (clk_pulses < 3 && n < 1400) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_third_pulse", clk_pulses, 3);
    repeat (36) @(negedge clk);
    check("mid_bit4_strobe", strobe, 1);
    check("mid_bit4_jclk", joypad_clock, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_strobe", strobe, 0);
    check("mid_rst_jclk", joypad_clock, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    clear_mon();
    repeat (600) @(negedge clk);
    check("mid_no_resend", busy_rises, 0);
    check("mid_no_capture", cap_q.size(), 0);

    // Loopback: write 0x90 then poll two bytes back
    clear_mon();
    dev_q.push_back(8'h11);
    dev_q.push_back(8'h22);
    tx_data = 8'h90; tx_valid = 1'b1; poll_en = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_busy(1'b1, 100, "lb_wr_start");
    wait_busy(1'b0, 1400, "lb_wr_done");
    wait_busy(1'b1, 100, "lb_rd1_start");
    wait_busy(1'b0, 600, "lb_rd1_done");
    wait_busy(1'b1, 100, "lb_rd2_start");
    poll_en = 1'b0;
    wait_busy(1'b0, 600, "lb_rd2_done");
    repeat (2) @(negedge clk);
    check("lb_captured", (cap_q.size() > 0) ? {24'd0, cap_q[0]} : 32'hffff_ffff, 8'h90);
    check("lb_rx_cnt", rx_cnt, 2);
    check("lb_rx_first", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hffff_ffff, 8'h11);
    check("lb_rx_second", (rx_q.size() > 1) ? {24'd0, rx_q[1]} : 32'hffff_ffff, 8'h22);

    check("lines_change_on_tick_only", change_viol, 0);
    check("strobe_low_gap", gap_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
